// File: rtl/alu_seq_unit.sv
// Registered EX-stage ALU with valid/ready handshake and held results.
// Define ALU_SEQ_MDU_EN to build in the iterative multiply/divide unit.
module alu_seq_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, res_d;
  logic             zero_q, ovf_q, ovf_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             accept, load, mdu_start;
  logic [SHW-1:0]   shamt;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

  // Single-cycle datapath evaluated on the operands being accepted.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = a - b;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0110: alu_res = a ^ b;
      4'b0111: alu_res = ~(a | b);
      4'b1000: alu_res = a << shamt;
      4'b1001: alu_res = a >> shamt;
      4'b1010: alu_res = $signed(a) >>> shamt;
`ifdef ALU_SEQ_MDU_EN
      // Only reached on divide by zero; other MDU ops iterate.
      4'b1110: alu_res = '1;
      4'b1111: alu_res = a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MDU_EN
  localparam int CW = SHW + 1;
  localparam logic [SHW:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] prod_q, step;
  logic [WIDTH-1:0]   dvs_q, mdu_res;
  logic [1:0]         mop_q;
  logic [SHW:0]       cnt_q;
  logic [WIDTH:0]     msum, rsh, rdif;

  assign mdu_start = accept && (alu_opcode[3:2] == 2'b11) &&
                     !(alu_opcode[1] && (b == '0));

  // One shift-add or restoring-divide step on {hi, lo}.
  always_comb begin
    msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
           (prod_q[0] ? {1'b0, dvs_q} : '0);
    rsh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    rdif = rsh - {1'b0, dvs_q};
    step = {msum, prod_q[WIDTH-1:1]};
    if (mop_q[1]) begin
      if (rdif[WIDTH])
        step = {rsh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      else
        step = {rdif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end
    mdu_res = mop_q[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
  end

  // Product/quotient register and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      dvs_q  <= '0;
      mop_q  <= '0;
      cnt_q  <= '0;
    end else if (mdu_start) begin
      prod_q <= {{WIDTH{1'b0}}, a};
      dvs_q  <= b;
      mop_q  <= alu_opcode[1:0];
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      prod_q <= step;
      cnt_q  <= cnt_q + CW'(1);
    end
  end
`else
  assign mdu_start = 1'b0;
`endif

  // Next state and result-load decision.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = alu_res;
    ovf_d   = alu_ovf;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready)
          state_d = IDLE;
        if (accept) begin
          if (mdu_start) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
`ifdef ALU_SEQ_MDU_EN
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          load    = 1'b1;
          res_d   = mdu_res;
          ovf_d   = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result and flags, held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      result_q <= res_d;
      zero_q   <= (res_d == '0);
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit (WIDTH = 32).
// Covers the MDU path when ALU_SEQ_MDU_EN is defined.
module tb_alu_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_opcode (alu_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        v;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV] = '{
    '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1},
    '{4'b0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0},
    '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
    '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0},
    '{4'b0011, 32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 1'b0},
    '{4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
    '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{4'b0110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0},
    '{4'b0111, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
    '{4'b1000, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0},
    '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
    '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
    '{4'b1011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0}
  };

  task automatic run_op(input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, output int lat,
                        output bit rb);
    alu_opcode = op;
    a          = x;
    b          = y;
    in_valid   = 1'b1;
    rb         = 1'b0;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    a          = 32'hDEAD_BEEF;
    b          = 32'h1234_5678;
    alu_opcode = 4'h0;
    lat        = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rb = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({result, zero, overflow, out_valid, in_ready} !==
        {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: res=%h z=%b ov=%b ovld=%b rdy=%b",
               result, zero, overflow, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL idle_hold: ovld=%b res=%h, want 0/0",
               out_valid, result);
    end
  endtask

  task automatic test_single;
    int lat;
    bit rb;
    for (int i = 0; i < NV; i++) begin
      run_op(tv[i].op, tv[i].x, tv[i].y, lat, rb);
      checks++;
      if (lat !== 1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL lat op%0d: got %0d want 1", i, lat);
      end
      checks++;
      if (result !== tv[i].r) begin
        errors++;
        $display("FAIL res op%0d: got %h want %h", i, result, tv[i].r);
      end
      checks++;
      if (zero !== (tv[i].r == 32'h0) || overflow !== tv[i].v) begin
        errors++;
        $display("FAIL flags op%0d: z=%b ov=%b want z=%b ov=%b",
                 i, zero, overflow, tv[i].r == 32'h0, tv[i].v);
      end
    end
  endtask

`ifdef ALU_SEQ_MDU_EN
  task automatic test_mdu;
    logic [3:0]  mop [8] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111,
                             4'b1110, 4'b1111, 4'b1100, 4'b1110};
    logic [31:0] mx  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                             32'd100, 32'd9, 32'd9, 32'h0001_0000,
                             32'hFFFF_FFFF};
    logic [31:0] my  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                             32'd0, 32'h0001_0000, 32'h10};
    logic [31:0] mr  [8] = '{32'hFFFF_FFFE, 32'd1, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd9, 32'd0,
                             32'h0FFF_FFFF};
    int          ml  [8] = '{33, 33, 33, 33, 1, 1, 33, 33};
    int lat;
    bit rb;
    for (int i = 0; i < 8; i++) begin
      run_op(mop[i], mx[i], my[i], lat, rb);
      checks++;
      if (lat !== ml[i]) begin
        errors++;
        $display("FAIL mdu_lat%0d: got %0d want %0d", i, lat, ml[i]);
      end
      checks++;
      if (result !== mr[i] || zero !== (mr[i] == 32'h0) ||
          overflow !== 1'b0) begin
        errors++;
        $display("FAIL mdu_res%0d: got %h z=%b ov=%b want %h",
                 i, result, zero, overflow, mr[i]);
      end
      checks++;
      if (rb !== 1'b0) begin
        errors++;
        $display("FAIL mdu_busy_rdy%0d: in_ready seen 1, want 0", i);
      end
    end
  endtask
`else
  task automatic test_mdu;
    int lat;
    bit rb;
    logic [3:0] op;
    for (int i = 12; i < 16; i++) begin
      op = 4'(i);
      run_op(op, 32'd5, 32'd3, lat, rb);
      checks++;
      if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL nomdu%0d: lat=%0d res=%h z=%b want 1/0/1",
                 i, lat, result, zero);
      end
    end
  endtask
`endif

  task automatic test_backpressure;
    int lat;
    bit rb;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run_op(4'b0000, 32'd3, 32'd4, lat, rb);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd7 ||
          in_ready !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: ovld=%b res=%h rdy=%b want 1/7/0",
                 i, out_valid, result, in_ready);
      end
    end
    alu_opcode = 4'b0001;
    a          = 32'd10;
    b          = 32'd4;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd6) begin
      errors++;
      $display("FAIL bp_accept: ovld=%b res=%h want 1/6",
               out_valid, result);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  bop [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0110};
    logic [31:0] bx  [4] = '{32'd1, 32'd2, 32'd9, 32'hF};
    logic [31:0] by  [4] = '{32'd1, 32'd2, 32'd1, 32'h1};
    logic [31:0] br  [4] = '{32'd2, 32'd4, 32'd8, 32'hE};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_opcode = bop[i];
      a          = bx[i];
      b          = by[i];
      in_valid   = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_rdy%0d: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== br[i]) begin
        errors++;
        $display("FAIL b2b%0d: ovld=%b res=%h want 1/%h",
                 i, out_valid, result, br[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'hE) begin
      errors++;
      $display("FAIL b2b_idle: ovld=%b res=%h want 0/e",
               out_valid, result);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit rb;
    out_ready = 1'b1;
    run_op(4'b0000, 32'd3, 32'd4, lat, rb);
`ifdef ALU_SEQ_MDU_EN
    alu_opcode = 4'b1110;
    a          = 32'd100;
    b          = 32'd7;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: rdy=%b ovld=%b want 0/0",
               in_ready, out_valid);
    end
`else
    out_ready = 1'b0;
    @(posedge clk);
    #1;
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({result, zero, overflow, out_valid, in_ready} !==
        {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: res=%h z=%b ov=%b ovld=%b rdy=%b",
               result, zero, overflow, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ovld=%b want 0", out_valid);
    end
`ifdef ALU_SEQ_MDU_EN
    run_op(4'b1111, 32'd100, 32'd7, lat, rb);
    checks++;
    if (result !== 32'd2 || lat !== 33) begin
      errors++;
      $display("FAIL post_reset_op: res=%h lat=%0d want 2/33",
               result, lat);
    end
`else
    run_op(4'b0000, 32'd20, 32'd22, lat, rb);
    checks++;
    if (result !== 32'd42 || lat !== 1) begin
      errors++;
      $display("FAIL post_reset_op: res=%h lat=%0d want 2a/1",
               result, lat);
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    alu_opcode = '0;
    test_reset();
    test_single();
    test_mdu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered ALU for the MIPS pipeline EX stage. It is the next generation of the combinational ALU: a wider opcode set, signed compare and overflow flag, and an optional iterative multiply/divide unit. Operands are accepted through a valid/ready handshake and the result is held under output back-pressure, so the hazard unit can stall on `in_ready` low during multi-cycle operations.

## Interface
- `WIDTH`, 32, datapath width. Power of two, ≥ 4.
- `SHW`, $clog2(WIDTH), shift-amount width. Derived; do not override.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands and opcode are valid.
- `in_ready` output 1: unit can accept an operation this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `alu_opcode` input 4: operation select.
- `out_valid` output 1: `result`, `zero` and `overflow` are valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: operation result.
- `zero` output 1: `result == 0`.
- `overflow` output 1: signed overflow (ADD/SUB only, else 0).

## Operation
- Accept occurs when `in_valid && in_ready`. `a`, `b` and `alu_opcode` are latched at accept; later input changes are ignored.
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR.
  - 0100 SLT (signed); 0101 SLTU.
  - 0110 XOR; 0111 NOR.
  - 1000 SLL; 1001 SRL; 1010 SRA. Shift amount is `b[SHW-1:0]`.
  - 1011 reserved: result 0.
  - 1100 MUL (low WIDTH bits); 1101 MULHU (high WIDTH bits of the unsigned product).
  - 1110 DIVU; 1111 REMU.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. `overflow` = operand signs are equal (for SUB, A sign ≠ B sign) and the result sign differs from A's sign.
- MUL/MULHU: shift-add, one bit per cycle, 2·WIDTH-bit product register.
- DIVU/REMU: restoring division, one bit per cycle.
- Divide by zero: DIVU returns all-ones, REMU returns `a`. No iteration is performed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of a single-cycle op → DONE.
  - IDLE, accept of MUL/MULHU/DIVU/REMU → BUSY. Divide by zero goes directly → DONE.
  - BUSY, iteration counter reaches WIDTH → DONE.
  - DONE && `out_ready` with a new accept → DONE or BUSY, per the new opcode.
  - DONE && `out_ready` with no accept → IDLE.
  - DONE && !`out_ready` → DONE. Outputs are held stable.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`). Combinational from state and `out_ready`.
- `out_valid` = (state == DONE).
- `zero` and `overflow` are registered together with `result`.

## Timing
- Reset (asynchronous, any state, including mid-iteration):
  - State → IDLE; counter and product/quotient registers cleared.
  - `result` = 0, `zero` = 0, `overflow` = 0, `out_valid` = 0, `in_ready` = 1 after reset.
  - In-flight operation is discarded.
- Single-cycle ops: accepted at edge N, `out_valid` = 1 after edge N+1 (latency 1).
- MUL/MULHU/DIVU/REMU: accepted at edge N, `out_valid` = 1 after edge N+WIDTH+1. `in_ready` = 0 throughout BUSY.
- Divide by zero: latency 1.
- Back-to-back single-cycle ops with `out_ready` held high: throughput of 1 op per cycle.
- `in_valid` deasserted in IDLE: no state change, outputs hold their last values, `out_valid` = 0.

## Configuration
- `ALU_SEQ_MDU_EN` defined: multiply/divide datapath, iteration counter and BUSY state are compiled in, as described above.
- `ALU_SEQ_MDU_EN` undefined:
  - Opcodes 1100–1111 behave like 1011: result 0, `zero` = 1, latency 1.
  - BUSY is unreachable and `in_ready` depends only on IDLE/DONE.
  - No multiply/divide registers are synthesised.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1 → after 1 cycle: result 0x80000000, `overflow` = 1, `zero` = 0.
- SUB a=5, b=5 → result 0, `zero` = 1.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0.
- MUL a=0xFFFFFFFF, b=2, WIDTH=32 → `out_valid` 33 cycles after accept, result 0xFFFFFFFE. MULHU with the same operands → 1. `in_ready` = 0 during BUSY.
- DIVU a=100, b=7 → 14; REMU → 2. DIVU a=9, b=0 → 0xFFFFFFFF after 1 cycle; REMU → 9.
- Back-pressure and reset:
  - Hold `out_ready` = 0 in DONE for 5 cycles → outputs stable, `in_ready` = 0.
  - Raise `out_ready` with a new op on `in_valid` → accepted the same cycle.
  - Assert `rst_n` = 0 mid-DIVU → all outputs 0 immediately, state IDLE.
